cam_sccb_config: RTL and testbench

Camera register-configuration master for the OV7670 front end. After reset it walks a register list held in an external synchronous ROM and writes each entry to the sensor over the write-only SCCB bus (3-phase write). It raises `cam_done` when the list terminator is reached. The pixel capture stage ignores incoming frames until `cam_done` is high.

---
 rtl/cam_sccb_config.sv | 227 ++++++++++++++++++++++
 tb/tb_cam_sccb_config.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_sccb_config.sv
// OV7670 register-configuration master: walks a {reg, value} list from a synchronous ROM
// and writes each entry over SCCB as a 3-phase write, then raises cam_done.
module cam_sccb_config #(
  parameter int         CLK_FREQ     = 25_000_000,
  parameter int         SCCB_FREQ    = 100_000,
  parameter logic [7:0] DEV_ADDR     = 8'h42,
  parameter int         ADDR_W       = 8,
  parameter int         DELAY_CYCLES = CLK_FREQ / 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sioc,
  output logic              siod_out,
  output logic              siod_oe,
  output logic              busy,
  output logic              cam_done
);

  localparam int QTR_RAW = CLK_FREQ / (4 * SCCB_FREQ);
  localparam int QTR     = (QTR_RAW < 1) ? 1 : QTR_RAW;
  localparam int QW      = (QTR > 1) ? $clog2(QTR) : 1;
  localparam int DW      = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [QW-1:0]     QTR_LAST  = QW'(QTR - 1);
  localparam logic [DW-1:0]     DLY_LAST  = DW'(DELAY_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_START, S_BITS, S_STOP, S_GAP, S_DELAY, S_DONE
  } state_t;

  // Bits 8, 17 and 26 are the slave's don't-care acknowledge slots.
  function automatic logic dc_bit(input logic [4:0] b);
    return (b == 5'd8) || (b == 5'd17) || (b == 5'd26);
  endfunction

  state_t              state_r, state_s;
  logic                fetch_wait_r, fetch_wait_s;
  logic [QW-1:0]       qcnt_r, qcnt_s;
  logic [1:0]          q_r, q_s;
  logic [4:0]          bit_r, bit_s;
  logic [23:0]         shift_r, shift_s;
  logic [DW-1:0]       dly_r, dly_s;
  logic [ADDR_W-1:0]   rom_addr_r, rom_addr_s;
  logic                sioc_r, sioc_s, siod_r, siod_s, oe_r, oe_s;
  logic                busy_r, busy_s, done_r, done_s;
  logic                tick_s, bus_s, advance_s;

  assign tick_s = (qcnt_r == QTR_LAST);
  assign bus_s  = state_r inside {S_START, S_BITS, S_STOP, S_GAP};

  // Next-state sequencing and registered bus levels derived from the next state.
  always_comb begin
    state_s      = state_r;
    fetch_wait_s = fetch_wait_r;
    q_s          = q_r;
    bit_s        = bit_r;
    shift_s      = shift_r;
    dly_s        = DW'(0);
    rom_addr_s   = rom_addr_r;
    advance_s    = 1'b0;
    if (bus_s && !tick_s) qcnt_s = qcnt_r + QW'(1);
    else                  qcnt_s = QW'(0);

    case (state_r)
      S_FETCH: begin
        if (fetch_wait_r) begin
          state_s      = S_DECODE;
          fetch_wait_s = 1'b0;
        end else begin
          fetch_wait_s = 1'b1;
        end
      end
      S_DECODE: begin
        if (rom_data == 16'hFFFF) begin
          state_s = S_DONE;
        end else if (rom_data == 16'hFFF0) begin
          state_s = S_DELAY;
        end else begin
          shift_s = {DEV_ADDR, rom_data};
          state_s = S_START;
          q_s     = 2'd0;
          bit_s   = 5'd0;
        end
      end
      S_START: begin
        if (tick_s && q_r == 2'd1) begin
          state_s = S_BITS;
          q_s     = 2'd0;
        end else if (tick_s) begin
          q_s = q_r + 2'd1;
        end else begin
          q_s = q_r;
        end
      end
      S_BITS: begin
        if (tick_s && q_r == 2'd3) begin
          q_s = 2'd0;
          if (!dc_bit(bit_r)) shift_s = {shift_r[22:0], 1'b0};
          else                shift_s = shift_r;
          if (bit_r == 5'd26) state_s = S_STOP;
          else                bit_s   = bit_r + 5'd1;
        end else if (tick_s) begin
          q_s = q_r + 2'd1;
        end else begin
          q_s = q_r;
        end
      end
      S_STOP: begin
        if (tick_s && q_r == 2'd2) begin
          state_s = S_GAP;
          q_s     = 2'd0;
        end else if (tick_s) begin
          q_s = q_r + 2'd1;
        end else begin
          q_s = q_r;
        end
      end
      S_GAP: begin
        if (tick_s && q_r == 2'd3) advance_s = 1'b1;
        else if (tick_s)           q_s = q_r + 2'd1;
        else                       q_s = q_r;
      end
      S_DELAY: begin
        if (dly_r == DLY_LAST) advance_s = 1'b1;
        else                   dly_s     = dly_r + DW'(1);
      end
      S_DONE: begin
        if (restart) begin
          state_s      = S_FETCH;
          rom_addr_s   = '0;
          fetch_wait_s = 1'b0;
        end else begin
          state_s = S_DONE;
        end
      end
      default: state_s = S_FETCH;
    endcase

    // The last list slot ends the run rather than wrapping the address.
    if (advance_s) begin
      if (rom_addr_r == ADDR_LAST) begin
        state_s = S_DONE;
      end else begin
        rom_addr_s   = rom_addr_r + ADDR_W'(1);
        state_s      = S_FETCH;
        fetch_wait_s = 1'b0;
      end
    end else begin
      rom_addr_s = rom_addr_s;
    end

    sioc_s = 1'b1;
    siod_s = 1'b1;
    oe_s   = 1'b1;
    busy_s = 1'b1;
    done_s = 1'b0;
    case (state_s)
      S_START: siod_s = (q_s == 2'd0);
      S_BITS: begin
        sioc_s = q_s[1];
        if (dc_bit(bit_s)) begin
          siod_s = 1'b1;
          oe_s   = 1'b0;
        end else begin
          siod_s = shift_s[23];
          oe_s   = 1'b1;
        end
      end
      S_STOP: begin
        sioc_s = (q_s != 2'd0);
        siod_s = (q_s == 2'd2);
      end
      S_DONE: begin
        busy_s = 1'b0;
        done_s = 1'b1;
      end
      default: begin
        sioc_s = 1'b1;
        siod_s = 1'b1;
      end
    endcase
  end

  // State and output registers; reset forces idle bus levels immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_FETCH;
      fetch_wait_r <= 1'b0;
      qcnt_r       <= QW'(0);
      q_r          <= 2'd0;
      bit_r        <= 5'd0;
      shift_r      <= 24'd0;
      dly_r        <= DW'(0);
      rom_addr_r   <= '0;
      sioc_r       <= 1'b1;
      siod_r       <= 1'b1;
      oe_r         <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      fetch_wait_r <= fetch_wait_s;
      qcnt_r       <= qcnt_s;
      q_r          <= q_s;
      bit_r        <= bit_s;
      shift_r      <= shift_s;
      dly_r        <= dly_s;
      rom_addr_r   <= rom_addr_s;
      sioc_r       <= sioc_s;
      siod_r       <= siod_s;
      oe_r         <= oe_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
    end
  end

  assign rom_addr = rom_addr_r;
  assign sioc     = sioc_r;
  assign siod_out = siod_r;
  assign siod_oe  = oe_r;
  assign busy     = busy_r;
  assign cam_done = done_r;

endmodule

// File: tb/tb_cam_sccb_config.sv
// Directed bench for cam_sccb_config: ROM model, SCCB bus monitor and fixed-cycle checks.
module tb_cam_sccb_config;

  logic        clk;
  logic        rst, rst2;
  logic        restart, restart2;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        sioc, siod_out, siod_oe, busy, cam_done;
  logic [1:0]  rom_addr2;
  logic [15:0] rom_data2;
  logic        sioc2, siod_out2, siod_oe2, busy2, cam_done2;
  logic [15:0] rom  [0:255];
  logic [15:0] rom2 [0:3];
  logic        pad;

  int n_checks, n_fail, edge_n;
  int n_tog, n_start, n_stop, n_low4, n_low2, n_lowx, n_high4, n_oe8, n_oex, n_tx;
  int b_tog, b_start, b_stop, b_low4, b_low2, b_lowx, b_high4, b_oe8, b_oex, b_tx;
  logic [23:0] last_tx;

  cam_sccb_config #(.CLK_FREQ(800_000), .SCCB_FREQ(100_000), .DEV_ADDR(8'h42),
                    .ADDR_W(8), .DELAY_CYCLES(8000)) dut (
    .clk(clk), .rst(rst), .restart(restart), .rom_addr(rom_addr), .rom_data(rom_data),
    .sioc(sioc), .siod_out(siod_out), .siod_oe(siod_oe), .busy(busy), .cam_done(cam_done));

  cam_sccb_config #(.CLK_FREQ(800_000), .SCCB_FREQ(100_000), .DEV_ADDR(8'h42),
                    .ADDR_W(2), .DELAY_CYCLES(8000)) dut2 (
    .clk(clk), .rst(rst2), .restart(restart2), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .sioc(sioc2), .siod_out(siod_out2), .siod_oe(siod_oe2), .busy(busy2), .cam_done(cam_done2));

  assign pad = siod_oe ? siod_out : 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_ff @(posedge clk) begin
    rom_data  <= rom[rom_addr];
    rom_data2 <= rom2[rom_addr2];
  end

  // Bus monitor: decodes bytes on sioc rise, counts START/STOP and pulse widths.
  initial begin
    logic [26:0] acc;
    logic        p_sioc, p_pad;
    int          run_c, run_oe, nbits;
    acc = 27'd0; p_sioc = 1'b1; p_pad = 1'b1; run_c = 0; run_oe = 0; nbits = 0;
    n_tog = 0; n_start = 0; n_stop = 0; n_low4 = 0; n_low2 = 0; n_lowx = 0;
    n_high4 = 0; n_oe8 = 0; n_oex = 0; n_tx = 0; last_tx = 24'd0;
    forever begin
      @(negedge clk);
      if (sioc !== p_sioc) begin
        n_tog++;
        if (p_sioc) begin
          if (run_c == 4) n_high4++;
        end else begin
          if (run_c == 4)      n_low4++;
          else if (run_c == 2) n_low2++;
          else                 n_lowx++;
        end
        run_c = 1;
        if (sioc) begin
          acc = {acc[25:0], pad};
          nbits++;
          if (nbits == 27) begin
            last_tx = {acc[26:19], acc[17:10], acc[8:1]};
            n_tx++;
          end
        end
      end else begin
        run_c++;
        if (sioc && p_pad && !pad) begin n_start++; nbits = 0; end
        if (sioc && !p_pad && pad) n_stop++;
      end
      if (!siod_oe) run_oe++;
      else if (run_oe != 0) begin
        if (run_oe == 8) n_oe8++;
        else             n_oex++;
        run_oe = 0;
      end
      p_sioc = sioc;
      p_pad  = pad;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_tog = n_tog; b_start = n_start; b_stop = n_stop; b_low4 = n_low4; b_low2 = n_low2;
    b_lowx = n_lowx; b_high4 = n_high4; b_oe8 = n_oe8; b_oex = n_oex; b_tx = n_tx;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    edge_n = 0;
  endtask

  task automatic adv_to(input int k);
    while (edge_n < k) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk);
    edge_n++;
    #1 restart = 1'b0;
  endtask

  task automatic fill_rom(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    rom[0] = e0; rom[1] = e1; rom[2] = e2;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; edge_n = 0;
    rst = 1'b0; rst2 = 1'b0; restart = 1'b0; restart2 = 1'b0;
    rom2[0] = 16'h1100; rom2[1] = 16'h1101; rom2[2] = 16'h1102; rom2[3] = 16'h1103;
    fill_rom(16'h1280, 16'hFFFF, 16'hFFFF);
    #2 rst = 1'b1; rst2 = 1'b1;

    // Single write then terminator
    do_reset();
    snap();
    check_eq("rst sioc", 32'(sioc), 32'd1);
    check_eq("rst siod", 32'(siod_out), 32'd1);
    check_eq("rst oe", 32'(siod_oe), 32'd1);
    check_eq("rst addr", 32'(rom_addr), 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst done", 32'(cam_done), 32'd0);
    adv_to(1);
    check_eq("t1 busy", 32'(busy), 32'd1);
    adv_to(239);
    check_eq("t1 done early", 32'(cam_done), 32'd0);
    check_eq("t1 addr", 32'(rom_addr), 32'd1);
    adv_to(240);
    check_eq("t1 done", 32'(cam_done), 32'd1);
    check_eq("t1 busy low", 32'(busy), 32'd0);
    check_eq("t1 tx cnt", 32'(n_tx - b_tx), 32'd1);
    check_eq("t1 tx", 32'(last_tx), 32'h421280);
    check_eq("t1 oe win", 32'(n_oe8 - b_oe8), 32'd3);
    check_eq("t1 oe bad", 32'(n_oex - b_oex), 32'd0);
    check_eq("t1 start", 32'(n_start - b_start), 32'd1);
    check_eq("t1 stop", 32'(n_stop - b_stop), 32'd1);
    check_eq("t1 low4", 32'(n_low4 - b_low4), 32'd27);
    check_eq("t1 low2", 32'(n_low2 - b_low2), 32'd1);
    check_eq("t1 lowx", 32'(n_lowx - b_lowx), 32'd0);
    check_eq("t1 high4", 32'(n_high4 - b_high4), 32'd27);
    check_eq("t1 toggles", 32'(n_tog - b_tog), 32'd56);

    // Delay entry, write, terminator
    fill_rom(16'hFFF0, 16'h1100, 16'hFFFF);
    do_reset();
    snap();
    adv_to(8002);
    check_eq("t2 quiet", 32'(n_tog - b_tog), 32'd0);
    check_eq("t2 addr hold", 32'(rom_addr), 32'd0);
    adv_to(8003);
    check_eq("t2 addr inc", 32'(rom_addr), 32'd1);
    adv_to(8242);
    check_eq("t2 done early", 32'(cam_done), 32'd0);
    adv_to(8243);
    check_eq("t2 done", 32'(cam_done), 32'd1);
    check_eq("t2 addr end", 32'(rom_addr), 32'd2);
    check_eq("t2 tx", 32'(last_tx), 32'h421100);
    check_eq("t2 start", 32'(n_start - b_start), 32'd1);
    check_eq("t2 stop", 32'(n_stop - b_stop), 32'd1);

    // Terminator only
    fill_rom(16'hFFFF, 16'hFFFF, 16'hFFFF);
    do_reset();
    snap();
    adv_to(2);
    check_eq("t3 done early", 32'(cam_done), 32'd0);
    adv_to(3);
    check_eq("t3 done", 32'(cam_done), 32'd1);
    check_eq("t3 busy", 32'(busy), 32'd0);
    adv_to(20);
    check_eq("t3 toggles", 32'(n_tog - b_tog), 32'd0);

    // Restart ignored mid-transaction, honoured in DONE
    fill_rom(16'h1280, 16'hFFFF, 16'hFFFF);
    do_reset();
    snap();
    adv_to(100);
    pulse_restart();
    adv_to(239);
    check_eq("t4 done early", 32'(cam_done), 32'd0);
    adv_to(240);
    check_eq("t4 done", 32'(cam_done), 32'd1);
    adv_to(250);
    pulse_restart();
    check_eq("t4 rs done", 32'(cam_done), 32'd0);
    check_eq("t4 rs addr", 32'(rom_addr), 32'd0);
    check_eq("t4 rs busy", 32'(busy), 32'd1);
    adv_to(251 + 239);
    check_eq("t4 done2 early", 32'(cam_done), 32'd0);
    adv_to(251 + 240);
    check_eq("t4 done2", 32'(cam_done), 32'd1);
    check_eq("t4 tx cnt", 32'(n_tx - b_tx), 32'd2);
    check_eq("t4 tx", 32'(last_tx), 32'h421280);
    check_eq("t4 start", 32'(n_start - b_start), 32'd2);
    check_eq("t4 lowx", 32'(n_lowx - b_lowx), 32'd0);

    // Reset during bit 5 of the value byte
    do_reset();
    adv_to(191);
    check_eq("t5 pre sioc", 32'(sioc), 32'd0);
    check_eq("t5 pre siod", 32'(siod_out), 32'd0);
    rst = 1'b1;
    #1;
    check_eq("t5 async sioc", 32'(sioc), 32'd1);
    check_eq("t5 async siod", 32'(siod_out), 32'd1);
    check_eq("t5 async oe", 32'(siod_oe), 32'd1);
    check_eq("t5 async busy", 32'(busy), 32'd0);
    do_reset();
    snap();
    adv_to(240);
    check_eq("t5 done", 32'(cam_done), 32'd1);
    check_eq("t5 tx cnt", 32'(n_tx - b_tx), 32'd1);
    check_eq("t5 tx", 32'(last_tx), 32'h421280);

    // Four-entry ROM with no terminator: stops at the last address
    @(negedge clk);
    rst2 = 1'b0;
    edge_n = 0;
    adv_to(237);
    check_eq("t6 addr1", 32'(rom_addr2), 32'd1);
    adv_to(947);
    check_eq("t6 done early", 32'(cam_done2), 32'd0);
    check_eq("t6 addr3", 32'(rom_addr2), 32'd3);
    adv_to(948);
    check_eq("t6 done", 32'(cam_done2), 32'd1);
    check_eq("t6 addr end", 32'(rom_addr2), 32'd3);
    check_eq("t6 busy", 32'(busy2), 32'd0);
    adv_to(960);
    check_eq("t6 no wrap", 32'(rom_addr2), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
